// File: rtl/palindrome_pkg.sv
// Shared types and width helpers for the sequential palindrome checker.
package palindrome_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reversed value needs one extra digit's worth of headroom over the operand.
    function automatic int calc_rev_w(input int width, input int radix);
        return width + $clog2(radix);
    endfunction

    function automatic int calc_dcnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/palindrome_digit_step.sv
// One base-RADIX digit step: peel the low digit off temp and append it to rev.
module palindrome_digit_step #(
    parameter int WIDTH = 16,
    parameter int RADIX = 10,
    parameter int REV_W = WIDTH + $clog2(RADIX)
) (
    input  logic [WIDTH-1:0] temp,
    input  logic [REV_W-1:0] rev,
    output logic [WIDTH-1:0] temp_next,
    output logic [REV_W-1:0] rev_next
);

    localparam logic [WIDTH-1:0] RAD_T = WIDTH'(RADIX);
    localparam logic [REV_W-1:0] RAD_R = REV_W'(RADIX);

    assign temp_next = temp / RAD_T;
    assign rev_next  = rev * RAD_R + REV_W'(temp % RAD_T);

endmodule

// File: rtl/palindrome_check_seq.sv
// Sequential palindrome checker: one digit per cycle, valid/ready on both sides.
module palindrome_check_seq
    import palindrome_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RADIX = 10,
    localparam int REV_W  = calc_rev_w(WIDTH, RADIX),
    localparam int DCNT_W = calc_dcnt_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  number,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              is_palindrome,
    output logic [REV_W-1:0]  rev_number,
    output logic [DCNT_W-1:0] digit_count,
    output logic              busy
);

    state_t              state, state_d;
    logic [WIDTH-1:0]    orig, temp, temp_nxt;
    logic [REV_W-1:0]    rev, rev_nxt;
    logic [DCNT_W-1:0]   cnt;

    palindrome_digit_step #(
        .WIDTH(WIDTH),
        .RADIX(RADIX),
        .REV_W(REV_W)
    ) u_step (
        .temp     (temp),
        .rev      (rev),
        .temp_next(temp_nxt),
        .rev_next (rev_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid)    state_d = RUN;
            RUN:     if (temp == '0)  state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Result registers only load on the RUN->DONE step; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig          <= '0;
            temp          <= '0;
            rev           <= '0;
            cnt           <= '0;
            is_palindrome <= 1'b0;
            rev_number    <= '0;
            digit_count   <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: if (in_valid) begin
                    orig <= number;
                    temp <= number;
                    rev  <= '0;
                    cnt  <= '0;
                end
                RUN: if (temp != '0) begin
                    temp <= temp_nxt;
                    rev  <= rev_nxt;
                    cnt  <= cnt + DCNT_W'(1);
                end else begin
                    is_palindrome <= (rev == REV_W'(orig));
                    rev_number    <= rev;
                    digit_count   <= cnt;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);

endmodule
